// File: rtl/bxu_pkg.sv
// Shared BXU definitions.
// Holds the data-memory command encodings, the data-address register
// command encodings and the data-memory stage state enumeration, so the
// decoder, the address stage and the memory stage all use one definition.
package bxu_pkg;

  // Data-memory commands driven by the decoder on flag_op_dmem.
  // 2'h3 is unassigned and behaves as NOP.
  localparam logic [1:0] DMEM_NOP = 2'h0;
  localparam logic [1:0] DMEM_LD  = 2'h1;
  localparam logic [1:0] DMEM_ST  = 2'h2;

  // Data-address register commands.
  localparam logic [1:0] DADDR_NOP   = 2'h0;
  localparam logic [1:0] DADDR_LD_LO = 2'h1;
  localparam logic [1:0] DADDR_LD_HI = 2'h2;
  localparam logic [1:0] DADDR_INC   = 2'h3;

  // Data-memory stage states.
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_REQ  = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_t;

  // True for commands that start a memory access.
  function automatic logic dmem_is_access(input logic [1:0] cmd);
    return (cmd == DMEM_LD) || (cmd == DMEM_ST);
  endfunction

endpackage

// File: rtl/op_dmem_timer.sv
// Access timeout counter for op_dmem.
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   clr     - synchronous clear (held while the access stage is idle)
//   en      - count enable (high while a request is outstanding)
//   expired - high in the last allowed request cycle
// With TIMEOUT_CYCLES = 0 the timeout is disabled and expired is tied low.
module op_dmem_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr, en};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt;

      // The request phase leaves at terminal count, so the hold at TERM
      // only guards against wrap and never changes observable behaviour.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en && (cnt != TERM)) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign expired = en && (cnt == TERM);
    end
  endgenerate

endmodule

// File: rtl/op_dmem.sv
// Data-memory access stage of the BXU core.
// Executes one load or store per accepted command over a req/ack memory
// handshake, stalls the core through busy while the access is outstanding,
// and aborts after TIMEOUT_CYCLES request cycles without an ack.
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   flag_op_dmem  - command (NOP/LD/ST, 2'h3 = NOP), sampled only when idle
//   data_addr     - access address from the data-address register
//   wr_data       - store data
//   data          - last successfully loaded word
//   busy          - access in progress (state not idle)
//   done          - one-cycle pulse when an access completes or aborts
//   err, err_clr  - sticky timeout flag and its clear
//   mem_*         - memory request/ack interface
module op_dmem
  import bxu_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH  = 8,
  parameter int unsigned ADDR_BITWIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               flag_op_dmem,
  input  logic [ADDR_BITWIDTH-1:0] data_addr,
  input  logic [DATA_BITWIDTH-1:0] wr_data,
  output logic [DATA_BITWIDTH-1:0] data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic                     err_clr,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_BITWIDTH-1:0] mem_addr,
  output logic [DATA_BITWIDTH-1:0] mem_wdata,
  input  logic [DATA_BITWIDTH-1:0] mem_rdata,
  input  logic                     mem_ack
);

  dmem_state_t state, state_nx;
  logic        accept;
  logic        expired;
  logic        timeout;

  assign accept  = (state == DMEM_IDLE) && dmem_is_access(flag_op_dmem);
  // An ack in the terminal cycle completes the access instead of aborting it.
  assign timeout = (state == DMEM_REQ) && expired && !mem_ack;

  op_dmem_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == DMEM_IDLE),
    .en      (state == DMEM_REQ),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DMEM_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      DMEM_IDLE: if (accept) state_nx = DMEM_REQ;
      DMEM_REQ:  if (mem_ack || expired) state_nx = DMEM_DONE;
      DMEM_DONE: state_nx = DMEM_IDLE;
      default:   state_nx = DMEM_IDLE;
    endcase
  end

  // Request fields are captured at accept and stay frozen until the next
  // accept, so they are stable for the whole request phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (accept) begin
      mem_addr  <= data_addr;
      mem_wdata <= wr_data;
      mem_we    <= (flag_op_dmem == DMEM_ST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if ((state == DMEM_REQ) && mem_ack && !mem_we) begin
      data <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  assign busy    = (state != DMEM_IDLE);
  assign mem_req = (state == DMEM_REQ);
  assign done    = (state == DMEM_DONE);

endmodule

// File: tb/tb_op_dmem.sv
module tb_op_dmem;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int          T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    flag_op_dmem = 2'h0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] data;
  logic          busy, done, err;
  logic          err_clr = 1'b0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int ncmp  = 0;
  int nfail = 0;

  // Reference state: a 16-word memory indexed by the low address nibble,
  // the last loaded word and the sticky error flag.
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] ref_data = '0;
  logic          ref_err  = 1'b0;

  always #5 clk = ~clk;

  op_dmem #(
    .DATA_BITWIDTH  (DW),
    .ADDR_BITWIDTH  (AW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flag_op_dmem (flag_op_dmem),
    .data_addr    (data_addr),
    .wr_data      (wr_data),
    .data         (data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_clr      (err_clr),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".req"},  32'(mem_req), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".data"}, 32'(data), 32'(ref_data));
    check({tag, ".err"},  32'(err), 32'(ref_err));
  endtask

  // One access. Entered and left at a negedge with the DUT idle.
  // ack_at: index of the request cycle carrying the ack (<0 or >=T: none).
  // clr_last: assert err_clr during the last request cycle.
  task automatic run_txn(input string tag, input logic [1:0] cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int ack_at, input bit clr_last);
    bit            acked;
    int            n_req;
    logic [DW-1:0] rd;
    logic          err_before;
    acked      = (ack_at >= 0) && (ack_at < T);
    n_req      = acked ? ack_at + 1 : T;
    rd         = ref_mem[addr[3:0]];
    err_before = ref_err;
    if (acked && cmd == 2'h1) ref_data = rd;
    if (acked && cmd == 2'h2) ref_mem[addr[3:0]] = wd;
    if (!acked) ref_err = 1'b1;
    else if (clr_last) ref_err = 1'b0;

    flag_op_dmem = cmd;
    data_addr    = addr;
    wr_data      = wd;
    mem_ack      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < n_req; i++) begin
      check({tag, ".req"},   32'(mem_req), 32'd1);
      check({tag, ".busy"},  32'(busy), 32'd1);
      check({tag, ".done"},  32'(done), 32'd0);
      check({tag, ".addr"},  32'(mem_addr), 32'(addr));
      check({tag, ".we"},    32'(mem_we), (cmd == 2'h2) ? 32'd1 : 32'd0);
      check({tag, ".wdata"}, 32'(mem_wdata), 32'(wd));
      if (i == 0) check({tag, ".err_hold"}, 32'(err), 32'(err_before));
      // Commands and operands change while busy and must be ignored.
      flag_op_dmem = 2'($urandom_range(3, 1));
      data_addr    = AW'($urandom);
      wr_data      = DW'($urandom);
      mem_ack      = acked && (i == ack_at);
      mem_rdata    = (mem_ack && cmd == 2'h1) ? rd : DW'($urandom);
      err_clr      = clr_last && (i == n_req - 1);
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    err_clr   = 1'b0;
    mem_rdata = DW'($urandom);
    check({tag, ".done_pulse"}, 32'(done), 32'd1);
    check({tag, ".done_req"},   32'(mem_req), 32'd0);
    check({tag, ".done_busy"},  32'(busy), 32'd1);
    check({tag, ".data"},       32'(data), 32'(ref_data));
    check({tag, ".err"},        32'(err), 32'(ref_err));
    @(negedge clk);
    flag_op_dmem = 2'h0;
    check_idle({tag, ".after"});
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    ref_err = 1'b0;
    check({tag, ".err_clr"}, 32'(err), 32'd0);
  endtask

  initial begin
    #300000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]    c;
    logic [AW-1:0] a;
    int            d;

    for (int i = 0; i < 16; i++) ref_mem[i] = DW'($urandom);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.addr",  32'(mem_addr), 32'd0);
    check("rst.wdata", 32'(mem_wdata), 32'd0);
    check("rst.we",    32'(mem_we), 32'd0);
    check_idle("rst");
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait load
    ref_mem[4] = 8'hA5;
    run_txn("ld0", 2'h1, 16'h1234, 8'h00, 0, 1'b0);

    // Wait-state store, 4 wait cycles
    run_txn("st4", 2'h2, 16'h00FF, 8'h3C, 4, 1'b0);

    // Load back what was stored
    run_txn("ldback", 2'h1, 16'h00FF, 8'h11, 2, 1'b0);

    // Timeout, then clear
    run_txn("tmo", 2'h1, 16'h0042, 8'h00, -1, 1'b0);
    clear_err("tmo");

    // Timeout with a simultaneous clear: the set must win
    run_txn("tmo_clr", 2'h2, 16'h0043, 8'h77, -1, 1'b1);
    clear_err("tmo_clr");

    // Ack on the final allowed request cycle: completes, no error
    run_txn("ack_last", 2'h1, 16'h0045, 8'h00, T - 1, 1'b0);

    // NOP encoding 3 and spurious acks in idle
    for (int i = 0; i < 4; i++) begin
      flag_op_dmem = (i % 2 == 0) ? 2'h3 : 2'h0;
      mem_ack      = 1'b1;
      mem_rdata    = DW'($urandom);
      @(negedge clk);
      check_idle("idle_ign");
    end
    mem_ack      = 1'b0;
    flag_op_dmem = 2'h0;

    // Reset in the middle of a request
    flag_op_dmem = 2'h1;
    data_addr    = 16'h0007;
    @(posedge clk);
    @(negedge clk);
    flag_op_dmem = 2'h0;
    check("mid.req", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    ref_data = '0;
    ref_err  = 1'b0;
    check_idle("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn("post_rst", 2'h1, 16'h0007, 8'h00, 1, 1'b0);

    // Randomized accesses
    for (int n = 0; n < 30; n++) begin
      c = ($urandom_range(1, 0) == 0) ? 2'h1 : 2'h2;
      a = AW'($urandom);
      d = int'($urandom_range(T + 2, 0));
      run_txn("rnd", c, a, DW'($urandom), d, 1'b0);
      if (ref_err) clear_err("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
